alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Controller that time-shares the single-cycle ALU datapath between two requesters, e.g. requester 0 = main execute path, requester 1 = branch/address helper.
- Arbitrates requests and captures the winner's operands.
- Drives the ALU for one cycle, or for MUL_CYCLES cycles on multiply (ctrl 4'b1011), then returns the registered result and zero flag over a valid/ready response channel.
- Sits between the requesters and the ALU instance; the ALU stays purely combinational.

Parameters:
- DATA_W, 32: operand/result width.
- MUL_CYCLES, 4: EXEC cycles held for the multiply op (>=1).
- MUL_OP, 4'b1011: ctrl code treated as multi-cycle.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-low.
- req_valid_i  in  2  per-requester request valid, bit k = requester k.
- req_ready_o  out  2  per-requester request accept.
- req_ctrl_i  in  8  {ctrl1, ctrl0}, 4 bits each.
- req_src1_i  in  2*DATA_W  {src1 of req1, src1 of req0}.
- req_src2_i  in  2*DATA_W  {src2 of req1, src2 of req0}.
- req_shamt_i  in  2*DATA_W  {shamt of req1, shamt of req0}.
- rsp_valid_o  out  2  response valid, one-hot to the owner.
- rsp_ready_i  in  2  response accept.
- rsp_result_o  out  DATA_W  registered result, shared by both requesters.
- rsp_zero_o  out  1  registered zero flag.
- alu_src1_o / alu_src2_o / alu_shamt_o  out  DATA_W each  to the ALU.
- alu_ctrl_o  out  4  to the ALU.
- alu_result_i  in  DATA_W  from the ALU.
- alu_zero_i  in  1  from the ALU.

Behaviour:
- Reset (rst_i==0 at a clk_i edge): state=IDLE, last_grant=1 so requester 0 wins first, cnt=0.
  - Operand regs cleared; alu_*_o=0.
  - rsp_valid_o=0, rsp_result_o=0, rsp_zero_o=0.
  - A reset mid-operation drops the op silently; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready_o is combinational: one-hot to the grant winner, and only when that requester's valid is set.
  - Both valid: winner = requester other than last_grant (round-robin). Single valid: that requester wins.
  - On handshake: capture ctrl/src1/src2/shamt and the owner; load cnt = (ctrl==MUL_OP) ? MUL_CYCLES-1 : 0; go to EXEC.
  - req_ready_o=0 in every other state.
- EXEC:
  - alu_*_o driven from the captured regs, stable for the whole state.
  - cnt!=0: decrement and stay.
  - cnt==0: register alu_result_i into rsp_result_o and alu_zero_i into rsp_zero_o; go to RESP.
  - Result and zero are captured for every ctrl code, including 4'b1100-4'b1111, which are passed through unmodified.
- RESP:
  - rsp_valid_o[owner]=1; result and zero are held until rsp_ready_i[owner]=1.
  - On handshake: last_grant=owner, go to IDLE.
  - rsp_ready_i of the non-owner is ignored.
- Latency: accept at edge T gives rsp_valid_o high after edge T+1 for non-multiply, and after edge T+MUL_CYCLES for multiply.
  - Minimum issue interval is 3 cycles; a new accept is possible in the cycle after the response handshake.
- Protocol rule: req_valid_i[k] and its operands stay stable until accepted. Dropping valid before acceptance is a requester error (bench asserts).
- alu_*_o keep their last values in IDLE and RESP, so there is no spurious toggling.

Optional Feature:
- Macro ALU_SHARE_FIXED_PRIO_EN.
- Defined: requester 0 always wins a simultaneous request; last_grant is not used for arbitration.
- Undefined: round-robin as specified above.

Decomposition:
- Package alu_share_pkg holds:
  - ALU ctrl code constants (AND=0000, OR=0001, ADD=0010, SUB=0011, SLT=0100, SLL=0101, SRLV=0110, BEQ=0111, LUI=1000, BGT=1001, BNE=1010, MUL=1011).
  - FSM state typedef {IDLE, EXEC, RESP}.
- Sub-module rr_arb2: two-way grant logic.
  - Inputs: valid[1:0], last_grant. Output: one-hot grant[1:0].
  - Contains the ALU_SHARE_FIXED_PRIO_EN switch.

Test Plan:
- Single ADD: req0 ctrl=0010, src1=5, src2=7, rsp_ready=1 → rsp_valid[0] two edges after accept; result=12; rsp_valid[1]=0.
- Contention: both valid every cycle (req0 AND, req1 OR), rsp_ready=11 → grants alternate 0,1,0,1 starting with 0. With ALU_SHARE_FIXED_PRIO_EN, grants are always 0.
- Multiply, MUL_CYCLES=4: req1 ctrl=1011, 6×7 → alu_ctrl_o=1011 for exactly 4 cycles; rsp_result_o=42 after edge T+4.
- Response backpressure: BEQ 9,9 with rsp_ready held 0 for 5 cycles → rsp_valid[0] and rsp_zero_o=1 hold; req_ready_o=00 throughout; IDLE reached one edge after ready rises.
- Reset mid-EXEC: assert rst_i=0 during a multiply's 2nd EXEC cycle → all outputs 0 next edge, no rsp_valid ever issued, requester 0 wins next.

Source files
------------

// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared definitions for the ALU time-sharing controller.
//   - ALU control code constants understood by the shared ALU datapath.
//   - Controller FSM state type.
//   - onehot2(): turns a requester index into a one-hot 2-bit vector.
package alu_share_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRLV = 4'b0110;
  localparam logic [3:0] ALU_BEQ  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_BGT  = 4'b1001;
  localparam logic [3:0] ALU_BNE  = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: request/response bundle between the two requesters
// and the ALU sharing controller.
//   req_valid_i  [1:0]          per-requester request valid
//   req_ready_o  [1:0]          per-requester request accept
//   req_ctrl_i   [7:0]          {ctrl1, ctrl0}
//   req_src1_i   [2*DATA_W-1:0] {src1 of req1, src1 of req0}
//   req_src2_i   [2*DATA_W-1:0] {src2 of req1, src2 of req0}
//   req_shamt_i  [2*DATA_W-1:0] {shamt of req1, shamt of req0}
//   rsp_valid_o  [1:0]          response valid, one-hot to the owner
//   rsp_ready_i  [1:0]          response accept
//   rsp_result_o [DATA_W-1:0]   registered result
//   rsp_zero_o                  registered zero flag
// master = requester side, slave = controller side.
interface alu_share_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid_i;
  logic [1:0]          req_ready_o;
  logic [7:0]          req_ctrl_i;
  logic [2*DATA_W-1:0] req_src1_i;
  logic [2*DATA_W-1:0] req_src2_i;
  logic [2*DATA_W-1:0] req_shamt_i;
  logic [1:0]          rsp_valid_o;
  logic [1:0]          rsp_ready_i;
  logic [DATA_W-1:0]   rsp_result_o;
  logic                rsp_zero_o;

  modport master (
    output req_valid_i, req_ctrl_i, req_src1_i, req_src2_i, req_shamt_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o
  );

  modport slave (
    input  req_valid_i, req_ctrl_i, req_src1_i, req_src2_i, req_shamt_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_zero_o
  );
endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rr_arb2: two-way grant logic for the ALU sharing controller.
//   valid      [1:0]  request valid per requester
//   last_grant        requester that owned the previous completed op
//   grant      [1:0]  one-hot grant, zero when nothing is valid
// Build option ALU_SHARE_FIXED_PRIO_EN: requester 0 always wins a
// simultaneous request and last_grant is ignored. Default is round-robin.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef ALU_SHARE_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = 2'b00;
    if (valid[0])      grant = 2'b01;
    else if (valid[1]) grant = 2'b10;
  end
`else
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention: the requester that was not served last wins.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one combinational ALU between two requesters.
// Arbitrates, captures the winner's operands, holds them on the ALU for one
// cycle (MUL_CYCLES cycles for MUL_OP), then returns the registered result
// and zero flag on a valid/ready response channel.
//   clk_i, rst_i     clock, synchronous active-low reset
//   bus (slave)      request/response channels, see alu_share_ctrl_if
//   alu_src1_o, alu_src2_o, alu_shamt_o, alu_ctrl_o   operands to the ALU
//   alu_result_i, alu_zero_i                          ALU outputs
// Build option ALU_SHARE_FIXED_PRIO_EN (in rr_arb2): fixed priority to req 0.
//
// state | meaning
// IDLE  | waiting for a request; req_ready_o follows the arbiter grant
// EXEC  | captured operands on the ALU; cnt counts down extra multiply cycles
// RESP  | result held, rsp_valid_o[owner] high until the owner accepts
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter int         MUL_CYCLES = 4,
  parameter logic [3:0] MUL_OP     = 4'b1011
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_share_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [DATA_W-1:0] alu_shamt_o,
  output logic [3:0]        alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        grant;
  logic              win;
  logic              accept;
  logic [3:0]        ctrl_sel;
  logic [DATA_W-1:0] src1_sel;
  logic [DATA_W-1:0] src2_sel;
  logic [DATA_W-1:0] shamt_sel;

  rr_arb2 u_arb (
    .valid      (bus.req_valid_i),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign bus.req_ready_o = (state == IDLE) ? grant : 2'b00;
  assign accept          = |bus.req_ready_o;
  assign win             = grant[1];

  assign ctrl_sel  = win ? bus.req_ctrl_i[7:4] : bus.req_ctrl_i[3:0];
  assign src1_sel  = win ? bus.req_src1_i[2*DATA_W-1:DATA_W]  : bus.req_src1_i[DATA_W-1:0];
  assign src2_sel  = win ? bus.req_src2_i[2*DATA_W-1:DATA_W]  : bus.req_src2_i[DATA_W-1:0];
  assign shamt_sel = win ? bus.req_shamt_i[2*DATA_W-1:DATA_W] : bus.req_shamt_i[DATA_W-1:0];

  // The ALU operand registers are only loaded on accept, so the ALU inputs
  // stay quiet through RESP and IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      owner            <= 1'b0;
      cnt              <= '0;
      alu_ctrl_o       <= '0;
      alu_src1_o       <= '0;
      alu_src2_o       <= '0;
      alu_shamt_o      <= '0;
      bus.rsp_valid_o  <= 2'b00;
      bus.rsp_result_o <= '0;
      bus.rsp_zero_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner       <= win;
            alu_ctrl_o  <= ctrl_sel;
            alu_src1_o  <= src1_sel;
            alu_src2_o  <= src2_sel;
            alu_shamt_o <= shamt_sel;
            cnt         <= (ctrl_sel == MUL_OP) ? MUL_LOAD : '0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            bus.rsp_result_o <= alu_result_i;
            bus.rsp_zero_o   <= alu_zero_i;
            bus.rsp_valid_o  <= onehot2(owner);
            state            <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i[owner]) begin
            bus.rsp_valid_o <= 2'b00;
            last_grant      <= owner;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU model.
// Expected responses are queued when a request is issued and popped when
// the controller presents its response.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]    owner;
    logic [DW-1:0] result;
    logic          zero;
  } exp_t;

  logic          clk_i;
  logic          rst_i;
  logic [DW-1:0] alu_src1_o, alu_src2_o, alu_shamt_o;
  logic [3:0]    alu_ctrl_o;
  logic [DW-1:0] alu_result_i;
  logic          alu_zero_i;

  alu_share_ctrl_if #(.DATA_W(DW)) bus ();

  alu_share_ctrl #(.DATA_W(DW), .MUL_CYCLES(4), .MUL_OP(4'b1011)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus),
    .alu_src1_o   (alu_src1_o),
    .alu_src2_o   (alu_src2_o),
    .alu_shamt_o  (alu_shamt_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_result_i (alu_result_i),
    .alu_zero_i   (alu_zero_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural single-cycle ALU; 1100 is an extra code (xor) used to show
  // unlisted codes pass through the controller untouched.
  always_comb begin
    alu_result_i = '0;
    case (alu_ctrl_o)
      4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
      4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
      4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
      4'b0011: alu_result_i = alu_src1_o - alu_src2_o;
      4'b0100: alu_result_i = {31'd0, $signed(alu_src1_o) < $signed(alu_src2_o)};
      4'b0101: alu_result_i = alu_src2_o << alu_shamt_o[4:0];
      4'b0110: alu_result_i = alu_src2_o >> alu_src1_o[4:0];
      4'b0111: alu_result_i = alu_src1_o - alu_src2_o;
      4'b1000: alu_result_i = {alu_src2_o[15:0], 16'h0000};
      4'b1001: alu_result_i = {31'd0, $signed(alu_src1_o) > $signed(alu_src2_o)};
      4'b1010: alu_result_i = alu_src1_o - alu_src2_o;
      4'b1011: alu_result_i = alu_src1_o * alu_src2_o;
      4'b1100: alu_result_i = alu_src1_o ^ alu_src2_o;
      default: alu_result_i = '0;
    endcase
    alu_zero_i = (alu_result_i == '0);
  end

  int   ntotal = 0;
  int   npass  = 0;
  int   nfail  = 0;
  exp_t sb[$];

  // Requesters must hold valid until accepted.
  logic [1:0] pend = 2'b00;
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 2; k++)
        if (pend[k])
          assert (bus.req_valid_i[k] === 1'b1)
          else $error("FAIL protocol: req_valid[%0d] observed 0 expected 1 before accept", k);
      pend <= bus.req_valid_i & ~bus.req_ready_o;
    end else begin
      pend <= 2'b00;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [3:0] c, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] s);
    bus.req_ctrl_i[k*4 +: 4]    = c;
    bus.req_src1_i[k*DW +: DW]  = a;
    bus.req_src2_i[k*DW +: DW]  = b;
    bus.req_shamt_i[k*DW +: DW] = s;
  endtask

  task automatic push_exp(input logic [1:0] o, input logic [DW-1:0] r, input logic z);
    exp_t e;
    e.owner  = o;
    e.result = r;
    e.zero   = z;
    sb.push_back(e);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (bus.rsp_valid_o == 2'b00 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'(e.owner));
      chk({tag, "_result"}, 64'(bus.rsp_result_o), 64'(e.result));
      chk({tag, "_zero"}, 64'(bus.rsp_zero_o), 64'(e.zero));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_idx;

    rst_i           = 1'b0;
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b00;
    bus.req_ctrl_i  = '0;
    bus.req_src1_i  = '0;
    bus.req_src2_i  = '0;
    bus.req_shamt_i = '0;
    repeat (2) tick();

    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_result", 64'(bus.rsp_result_o), 64'd0);
    chk("rst_zero", 64'(bus.rsp_zero_o), 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl_o), 64'd0);
    chk("rst_alu_src1", 64'(alu_src1_o), 64'd0);
    rst_i = 1'b1;
    tick();

    // Single ADD from requester 0.
    bus.rsp_ready_i = 2'b11;
    set_req(0, ALU_ADD, 32'd5, 32'd7, 32'd0);
    bus.req_valid_i = 2'b01;
    #1;
    chk("add_ready", 64'(bus.req_ready_o), 64'h1);
    push_exp(2'b01, 32'd12, 1'b0);
    tick();
    bus.req_valid_i = 2'b00;
    wait_rsp(n);
    chk("add_latency", 64'(n), 64'd1);
    check_rsp("add");
    tick();

    // Unlisted ctrl code is executed and captured as-is.
    set_req(0, 4'b1100, 32'hA, 32'h3, 32'd0);
    bus.req_valid_i = 2'b01;
    #1;
    push_exp(2'b01, 32'h9, 1'b0);
    tick();
    bus.req_valid_i = 2'b00;
    wait_rsp(n);
    chk("xor_latency", 64'(n), 64'd1);
    check_rsp("xor");
    tick();

    // Multiply from requester 1: ALU held for 4 cycles.
    set_req(1, ALU_MUL, 32'd6, 32'd7, 32'd0);
    bus.req_valid_i = 2'b10;
    #1;
    chk("mul_ready", 64'(bus.req_ready_o), 64'h2);
    push_exp(2'b10, 32'd42, 1'b0);
    tick();
    bus.req_valid_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mul_ctrl_c%0d", i), 64'(alu_ctrl_o), 64'hB);
      chk($sformatf("mul_busy_c%0d", i), 64'(bus.rsp_valid_o), 64'd0);
      tick();
    end
    check_rsp("mul");
    tick();

    // BEQ with response backpressure; non-owner ready and a pending req1.
    bus.rsp_ready_i = 2'b00;
    set_req(0, ALU_BEQ, 32'd9, 32'd9, 32'd0);
    bus.req_valid_i = 2'b01;
    #1;
    push_exp(2'b01, 32'd0, 1'b1);
    tick();
    bus.req_valid_i = 2'b00;
    wait_rsp(n);
    chk("beq_latency", 64'(n), 64'd1);
    set_req(1, ALU_ADD, 32'd1, 32'd1, 32'd0);
    bus.req_valid_i = 2'b10;
    bus.rsp_ready_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_c%0d", i), 64'(bus.rsp_valid_o), 64'h1);
      chk($sformatf("bp_zero_c%0d", i), 64'(bus.rsp_zero_o), 64'h1);
      chk($sformatf("bp_ready_c%0d", i), 64'(bus.req_ready_o), 64'h0);
      tick();
    end
    check_rsp("beq");
    bus.rsp_ready_i = 2'b01;
    tick();
    chk("bp_idle_ready", 64'(bus.req_ready_o), 64'h2);
    push_exp(2'b10, 32'd2, 1'b0);
    tick();
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b11;
    wait_rsp(n);
    chk("add1_latency", 64'(n), 64'd1);
    check_rsp("add1");
    tick();

    // Reset during the second EXEC cycle of a multiply.
    set_req(0, ALU_MUL, 32'd3, 32'd3, 32'd0);
    bus.req_valid_i = 2'b01;
    #1;
    tick();
    bus.req_valid_i = 2'b00;
    tick();
    rst_i = 1'b0;
    tick();
    chk("mrst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("mrst_result", 64'(bus.rsp_result_o), 64'd0);
    chk("mrst_zero", 64'(bus.rsp_zero_o), 64'd0);
    chk("mrst_alu_ctrl", 64'(alu_ctrl_o), 64'd0);
    chk("mrst_alu_src1", 64'(alu_src1_o), 64'd0);
    chk("mrst_alu_src2", 64'(alu_src2_o), 64'd0);
    rst_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("mrst_quiet_c%0d", i), 64'(bus.rsp_valid_o), 64'd0);
    end

    // Contention: both requesters valid every cycle.
    set_req(0, ALU_AND, 32'hF0F0, 32'h0FF0, 32'd0);
    set_req(1, ALU_OR, 32'hF000, 32'h000F, 32'd0);
    bus.req_valid_i = 2'b11;
    #1;
    for (int r = 0; r < 4; r++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = r % 2;
`endif
      chk($sformatf("cont_grant_r%0d", r), 64'(bus.req_ready_o),
          64'(exp_idx == 0 ? 2'b01 : 2'b10));
      if (exp_idx == 0) push_exp(2'b01, 32'h00F0, 1'b0);
      else              push_exp(2'b10, 32'hF00F, 1'b0);
      tick();
      wait_rsp(n);
      chk($sformatf("cont_latency_r%0d", r), 64'(n), 64'd1);
      check_rsp($sformatf("cont_r%0d", r));
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
